exp_result_reader: RTL

- Consumer end of the exponential datapath's result write interface.
- Buffers 21-bit result words (2-bit integer part plus shifted fraction) in a small FIFO.
- Drains each word as three 7-bit chunks, most significant chunk first, over a valid/ready stream toward the display/output stage.
- Decouples engine throughput from a slow or back-pressuring consumer.

---
 rtl/exp_result_reader_if.sv | 31 +++
 rtl/exp_result_reader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/exp_result_reader_if.sv
// Result-write and chunk-stream bundle for exp_result_reader.
// master = datapath/consumer side, slave = reader.
interface exp_result_reader_if #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 21,
  parameter int CHUNK_W = 7
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic               full;
  logic               empty;
  logic [CW-1:0]      count;
  logic               out_ready;
  logic               out_valid;
  logic [CHUNK_W-1:0] out_data;
  logic               out_last;

  modport master (
    output wr_en, wr_data, out_ready,
    input  full, empty, count,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  wr_en, wr_data, out_ready,
    output full, empty, count,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/exp_result_reader.sv
// Buffers 21-bit exp results in a FIFO, streams each as 3 chunks MSB-first.
// Ports: clk, rst (async active-low), bus (slave), ovf if EXP_READER_OVF_EN.
module exp_result_reader #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 21,
  parameter int CHUNK_W = 7
) (
  input logic               clk,
  input logic               rst,
  exp_result_reader_if.slave bus
`ifdef EXP_READER_OVF_EN
  ,
  output logic              ovf
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              empty_q;
  logic              full_q;

  logic [DATA_W-1:0] shreg;
  logic [1:0]        idx;

  logic push;
  logic pop;
  logic hs;
  logic at_last;

  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.count = cnt;

  // Write side only sees registered full, so a same-cycle pop never
  // frees room for a write.
  assign push    = bus.wr_en && !full_q;
  assign at_last = (idx == 2'd2);
  assign hs      = bus.out_valid && bus.out_ready;

  // Load the shift register when idle, or right after the final chunk
  // so consecutive words stream without a bubble.
  assign pop = !empty_q &&
    ((state == IDLE) || (hs && at_last));

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wr_data;
  end

  always_comb begin
    cnt_n = cnt;
    unique case ({push, pop})
      2'b10:   cnt_n = cnt + CW'(1);
      2'b01:   cnt_n = cnt - CW'(1);
      default: cnt_n = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt     <= cnt_n;
      empty_q <= (cnt_n == '0);
      full_q  <= (cnt_n == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (pop) begin
      shreg <= mem[rptr];
      idx   <= '0;
    end else if (hs && !at_last) begin
      shreg <= shreg << CHUNK_W;
      idx   <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (!empty_q) state_n = SEND;
      end
      (state == SEND): begin
        if (hs && at_last && empty_q)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on out_ready.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_data  = shreg[DATA_W-1 -: CHUNK_W];
      bus.out_last  = at_last;
    end
  end

`ifdef EXP_READER_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     ovf <= 1'b0;
    else if (bus.wr_en && full_q) ovf <= 1'b1;
  end
`endif

endmodule
